x1_hilo_muldiv: RTL and testbench

- Multi-cycle multiply/divide unit with the architectural HI/LO register pair. It sits directly downstream of the X1 pipeline register.
- It consumes the issued op and the forwarded Rs/Rt data from X1, and runs MULT/DIV/MADD/MSUB/MTHI/MTLO.
- It holds Busy so the hazard unit stalls any HI/LO reader or any new mul/div until the result is committed.

---
 rtl/x1_hilo_muldiv.sv | 156 +++++++++++++++
 tb/tb_x1_hilo_muldiv.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/x1_hilo_muldiv.sv
// HI/LO multiply/divide unit: MUL family 2 busy cycles, DIV 33 (1 for divide-by-zero), MTHI/MTLO at issue.
// No backpressure port: Busy holds off new issues; X1_Abort kills an in-flight op before its write.
module x1_hilo_muldiv #(
  parameter logic [63:0] HILO_RESET = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        X1_Issue,
  input  logic [3:0]  X1_Op,
  input  logic [31:0] X1_RsData,
  input  logic [31:0] X1_RtData,
  input  logic        X1_Abort,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, DIV_ITER, DIV_FIX} state_t;

  state_t      state, state_nxt;
  logic        hilo_wr;

  logic [31:0] mul_a, mul_b;
  logic        mul_sgn;
  logic [1:0]  acc_mode;
  logic [63:0] product;

  logic [31:0] div_quo, div_rem, divisor;
  logic        q_neg, r_neg;
  logic [5:0]  div_cnt;

  // Bit 0 of the opcode selects the unsigned variant throughout the mul/div group.
  logic issue_ok, is_mul, is_div, is_mthi, is_mtlo, op_sgn, rt_zero;
  assign issue_ok = X1_Issue && !X1_Abort && (state == IDLE);
  assign is_mul   = (X1_Op[3:1] == 3'b000) || (X1_Op[3:2] == 2'b01);
  assign is_div   = (X1_Op[3:1] == 3'b001);
  assign is_mthi  = (X1_Op == 4'd8);
  assign is_mtlo  = (X1_Op == 4'd9);
  assign op_sgn   = ~X1_Op[0];
  assign rt_zero  = (X1_RtData == 32'd0);

  logic [31:0] rs_mag, rt_mag;
  assign rs_mag = (op_sgn && X1_RsData[31]) ? -X1_RsData : X1_RsData;
  assign rt_mag = (op_sgn && X1_RtData[31]) ? -X1_RtData : X1_RtData;

  logic [63:0] mul_a_ext, mul_b_ext, prod_full, mul_res;
  assign mul_a_ext = {{32{mul_sgn & mul_a[31]}}, mul_a};
  assign mul_b_ext = {{32{mul_sgn & mul_b[31]}}, mul_b};
  assign prod_full = mul_a_ext * mul_b_ext;

  always_comb begin
    mul_res = product;
    if (acc_mode == 2'b10)      mul_res = {HI, LO} + product;
    else if (acc_mode == 2'b11) mul_res = {HI, LO} - product;
  end

  // Restoring step: the dividend shifts out of div_quo while quotient bits shift in.
  logic [32:0] rem_shift, trial;
  assign rem_shift = {div_rem, div_quo[31]};
  assign trial     = rem_shift - {1'b0, divisor};

  always_comb begin
    state_nxt = state;
    hilo_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (issue_ok && is_mul)      state_nxt = MUL1;
        else if (issue_ok && is_div) state_nxt = rt_zero ? DIV_FIX : DIV_ITER;
      end
      MUL1:     state_nxt = MUL2;
      MUL2:     begin state_nxt = IDLE; hilo_wr = 1'b1; end
      DIV_ITER: if (div_cnt == 6'd31) state_nxt = DIV_FIX;
      DIV_FIX:  begin state_nxt = IDLE; hilo_wr = 1'b1; end
      default:  state_nxt = IDLE;
    endcase
    if (state != IDLE && X1_Abort) begin
      state_nxt = IDLE;
      hilo_wr   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      {HI, LO} <= HILO_RESET;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_sgn  <= 1'b0;
      acc_mode <= '0;
      product  <= '0;
      div_quo  <= '0;
      div_rem  <= '0;
      divisor  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_cnt  <= '0;
    end else begin
      Busy <= (state_nxt != IDLE);
      Done <= hilo_wr;
      case (state)
        IDLE: if (issue_ok) begin
          if (is_mul) begin
            mul_a    <= X1_RsData;
            mul_b    <= X1_RtData;
            mul_sgn  <= op_sgn;
            acc_mode <= X1_Op[2:1];
          end
          if (is_div) begin
            div_cnt <= '0;
            if (rt_zero) begin
              div_quo <= '1;
              div_rem <= X1_RsData;
              q_neg   <= 1'b0;
              r_neg   <= 1'b0;
            end else begin
              div_quo <= rs_mag;
              div_rem <= '0;
              divisor <= rt_mag;
              q_neg   <= op_sgn & (X1_RsData[31] ^ X1_RtData[31]);
              r_neg   <= op_sgn & X1_RsData[31];
            end
          end
          if (is_mthi) HI <= X1_RsData;
          if (is_mtlo) LO <= X1_RsData;
        end
        MUL1: product <= prod_full;
        DIV_ITER: begin
          div_cnt <= div_cnt + 6'd1;
          if (!trial[32]) begin
            div_rem <= trial[31:0];
            div_quo <= {div_quo[30:0], 1'b1};
          end else begin
            div_rem <= rem_shift[31:0];
            div_quo <= {div_quo[30:0], 1'b0};
          end
        end
        default: ;
      endcase
      if (hilo_wr) begin
        if (state == MUL2) {HI, LO} <= mul_res;
        else begin
          HI <= r_neg ? -div_rem : div_rem;
          LO <= q_neg ? -div_quo : div_quo;
        end
      end
    end
  end

endmodule

// File: tb/tb_x1_hilo_muldiv.sv
// Directed bench for x1_hilo_muldiv: busy length, Done pulse and HI/LO results against hand-computed values.
module tb_x1_hilo_muldiv;

  localparam logic [63:0] RST_VAL = 64'h1234_5678_9ABC_DEF0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        X1_Issue = 1'b0;
  logic [3:0]  X1_Op = 4'd0;
  logic [31:0] X1_RsData = '0;
  logic [31:0] X1_RtData = '0;
  logic        X1_Abort = 1'b0;
  logic [31:0] HI, LO;
  logic        Busy, Done;

  int checks = 0;
  int errors = 0;

  x1_hilo_muldiv #(.HILO_RESET(RST_VAL)) dut (
    .clock(clock), .reset(reset), .X1_Issue(X1_Issue), .X1_Op(X1_Op),
    .X1_RsData(X1_RsData), .X1_RtData(X1_RtData), .X1_Abort(X1_Abort),
    .HI(HI), .LO(LO), .Busy(Busy), .Done(Done)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (!reset) assert (!(X1_Issue && Busy)) else $error("issue while busy");

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    n = 0;
    X1_Issue = 1'b1; X1_Op = op; X1_RsData = rs; X1_RtData = rt;
    @(posedge clock); #1 X1_Issue = 1'b0;
    @(negedge clock);
    while (Busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk({tag, "_busy"}, 64'(n), 64'(exp_busy));
    chk({tag, "_done"}, 64'(Done), 64'd1);
    chk({tag, "_hi"}, 64'(HI), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(LO), 64'(exp_lo));
    @(negedge clock);
    chk({tag, "_done_clr"}, 64'(Done), 64'd0);
  endtask

  task automatic mt_op(input string tag, input logic [3:0] op, input logic [31:0] rs);
    X1_Issue = 1'b1; X1_Op = op; X1_RsData = rs;
    @(posedge clock); #1 X1_Issue = 1'b0;
    @(negedge clock);
    chk({tag, "_busy"}, 64'(Busy), 64'd0);
    chk({tag, "_done"}, 64'(Done), 64'd0);
  endtask

  initial begin
    #23 reset = 1'b0;
    @(negedge clock);
    chk("rst_hilo", {HI, LO}, RST_VAL);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);

    run_op("mult",  4'd0, 32'hFFFF_FFFF, 32'h2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 4'd1, 32'hFFFF_FFFF, 32'h2, 2, 32'h0000_0001, 32'hFFFF_FFFE);

    mt_op("mthi", 4'd8, 32'h0);
    chk("mthi_hilo", {HI, LO}, 64'h0000_0000_FFFF_FFFE);
    mt_op("mtlo", 4'd9, 32'h5);
    chk("mtlo_hilo", {HI, LO}, 64'h0000_0000_0000_0005);
    run_op("madd",  4'd4, 32'd3, 32'd4, 2, 32'h0, 32'd17);
    run_op("msubu", 4'd7, 32'h20, 32'h1, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    run_op("div_neg",  4'd2, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",     4'd3, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_op("divu_z",   4'd3, 32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF);
    run_op("div_z",    4'd2, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_ovf",  4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

    // Abort partway through a divide.
    mt_op("pre_hi", 4'd8, 32'hA);
    mt_op("pre_lo", 4'd9, 32'hB);
    X1_Issue = 1'b1; X1_Op = 4'd2; X1_RsData = 32'd50; X1_RtData = 32'd3;
    @(posedge clock); #1 X1_Issue = 1'b0;
    repeat (9) @(posedge clock);
    #1 X1_Abort = 1'b1;
    @(posedge clock); #1 X1_Abort = 1'b0;
    @(negedge clock);
    chk("abt_div_busy", 64'(Busy), 64'd0);
    chk("abt_div_done", 64'(Done), 64'd0);
    chk("abt_div_hilo", {HI, LO}, 64'h0000_000A_0000_000B);
    @(negedge clock);
    chk("abt_div_done2", 64'(Done), 64'd0);

    // Abort on the MUL2 write cycle.
    X1_Issue = 1'b1; X1_Op = 4'd0; X1_RsData = 32'd6; X1_RtData = 32'd7;
    @(posedge clock); #1 X1_Issue = 1'b0;
    @(posedge clock); #1 X1_Abort = 1'b1;
    @(posedge clock); #1 X1_Abort = 1'b0;
    @(negedge clock);
    chk("abt_mul_busy", 64'(Busy), 64'd0);
    chk("abt_mul_done", 64'(Done), 64'd0);
    chk("abt_mul_hilo", {HI, LO}, 64'h0000_000A_0000_000B);

    // Reset in the middle of a divide.
    @(negedge clock);
    X1_Issue = 1'b1; X1_Op = 4'd3; X1_RsData = 32'd50; X1_RtData = 32'd3;
    @(posedge clock); #1 X1_Issue = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", 64'(Busy), 64'd0);
    chk("rst_mid_done", 64'(Done), 64'd0);
    chk("rst_mid_hilo", {HI, LO}, RST_VAL);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Issue qualified by a same-cycle abort is dropped.
    X1_Issue = 1'b1; X1_Abort = 1'b1; X1_Op = 4'd0; X1_RsData = 32'd5; X1_RtData = 32'd5;
    @(posedge clock); #1 X1_Issue = 1'b0; X1_Abort = 1'b0;
    @(negedge clock);
    chk("iss_abt_busy", 64'(Busy), 64'd0);
    @(negedge clock);
    chk("iss_abt_done", 64'(Done), 64'd0);
    chk("iss_abt_hilo", {HI, LO}, RST_VAL);
    X1_Issue = 1'b1; X1_Abort = 1'b1; X1_Op = 4'd9; X1_RsData = 32'h55;
    @(posedge clock); #1 X1_Issue = 1'b0; X1_Abort = 1'b0;
    @(negedge clock);
    chk("iss_abt_mtlo", {HI, LO}, RST_VAL);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
